// File: rtl/lms_rx_iq_gen.sv
// LMS RX IQ generator: show-ahead sample-pair FIFO feeding an I/Q interleaved ADC-side output.
// Optional build macro LMS_RX_TESTPAT_EN adds a counter-based test-pattern source selected by testpat.
module lms_rx_iq_gen #(
  parameter int DEPTH_LOG2 = 3,
  parameter int DW         = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DW-1:0]         in_i,
  input  logic [DW-1:0]         in_q,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  testpat,
  output logic                  iqsel,
  output logic [DW-1:0]         data,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [15:0]           underflow_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH_I = 2'd1;
  localparam logic [1:0] PH_Q = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [DW-1:0]         mem_i_r [DEPTH];
  logic [DW-1:0]         mem_q_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic [DW-1:0]         q_hold_r;
  logic [DW-1:0]         data_r;
  logic                  iqsel_r;
  logic [15:0]           underflow_cnt_r;
  logic                  start_i_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  uf_inc_s;
  logic                  tp_sel_s;
  logic [DW-1:0]         tp_i_s;
  logic [DW-1:0]         tp_q_s;
  logic [DW-1:0]         src_i_s;
  logic [DW-1:0]         src_q_s;

  assign empty_s       = (level_r == {(DEPTH_LOG2+1){1'b0}});
  assign in_ready      = (level_r < FULL_LVL);
  assign push_s        = in_valid && in_ready;
  assign start_i_s     = (state_nxt_s == PH_I);
  assign pop_s         = start_i_s && !empty_s && !tp_sel_s;
  assign uf_inc_s      = start_i_s && empty_s && !tp_sel_s;
  assign iqsel         = iqsel_r;
  assign data          = data_r;
  assign fifo_level    = level_r;
  assign underflow_cnt = underflow_cnt_r;

`ifdef LMS_RX_TESTPAT_EN
  logic [DW-1:0] tp_cnt_r;

  assign tp_sel_s = testpat;
  assign tp_i_s   = tp_cnt_r;
  assign tp_q_s   = ~tp_cnt_r;

  // Pattern counter advances once per generated sample pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_cnt_r <= {DW{1'b0}};
    end else if (start_i_s && tp_sel_s) begin
      tp_cnt_r <= tp_cnt_r + DW'(1);
    end else begin
      tp_cnt_r <= tp_cnt_r;
    end
  end
`else
  logic unused_testpat_s;

  assign unused_testpat_s = testpat;
  assign tp_sel_s         = 1'b0;
  assign tp_i_s           = {DW{1'b0}};
  assign tp_q_s           = {DW{1'b0}};
`endif

  // Phase sequencing: a started sample always finishes its Q phase.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE:    state_nxt_s = enable ? PH_I : IDLE;
      PH_I:    state_nxt_s = PH_Q;
      PH_Q:    state_nxt_s = enable ? PH_I : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Source of the next sample pair; an empty FIFO yields zeros.
  always_comb begin
    src_i_s = {DW{1'b0}};
    src_q_s = {DW{1'b0}};
    if (tp_sel_s) begin
      src_i_s = tp_i_s;
      src_q_s = tp_q_s;
    end else if (!empty_s) begin
      src_i_s = mem_i_r[rd_ptr_r];
      src_q_s = mem_q_r[rd_ptr_r];
    end else begin
      src_i_s = {DW{1'b0}};
      src_q_s = {DW{1'b0}};
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_i_r[wr_ptr_r] <= in_i;
      mem_q_r[wr_ptr_r] <= in_q;
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the level unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + DEPTH_LOG2'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s  ? rd_ptr_r + DEPTH_LOG2'(1) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (DEPTH_LOG2+1)'(1);
        2'b01:   level_r <= level_r - (DEPTH_LOG2+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Output registers: I word at phase start, held Q word next, zeros when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      iqsel_r         <= 1'b0;
      data_r          <= {DW{1'b0}};
      q_hold_r        <= {DW{1'b0}};
      underflow_cnt_r <= 16'h0000;
    end else begin
      state_r <= state_nxt_s;
      if (start_i_s) begin
        iqsel_r  <= 1'b1;
        data_r   <= src_i_s;
        q_hold_r <= src_q_s;
      end else if (state_r == PH_I) begin
        iqsel_r  <= 1'b0;
        data_r   <= q_hold_r;
        q_hold_r <= q_hold_r;
      end else begin
        iqsel_r  <= 1'b0;
        data_r   <= {DW{1'b0}};
        q_hold_r <= q_hold_r;
      end
      if (uf_inc_s && (underflow_cnt_r != 16'hFFFF)) begin
        underflow_cnt_r <= underflow_cnt_r + 16'd1;
      end else begin
        underflow_cnt_r <= underflow_cnt_r;
      end
    end
  end

endmodule

// File: doc/lms_rx_iq_gen.md
LMS_RX_IQ_GEN -- requirements
Module: lms_rx_iq_gen

Interface
REQ-001 Parameter: DEPTH_LOG2, default 3, FIFO depth = 2^DEPTH_LOG2 sample pairs.
REQ-002 Parameter: DW, default 12, per-component sample width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port: clk  in  1  sole clock, LMS interface rate (2 clk per IQ sample).
REQ-005 Port: rst  in  1  synchronous active-high reset.
REQ-006 Port: enable  in  1  run interleaved output when high.
REQ-007 Port: in_i  in  DW  I component of input sample.
REQ-008 Port: in_q  in  DW  Q component of input sample.
REQ-009 Port: in_valid  in  1  input sample present.
REQ-010 Port: in_ready  out  1  FIFO can accept; transfer on in_valid&in_ready at rising clk.
REQ-011 Port: testpat  in  1  select test-pattern source (meaningful only with LMS_RX_TESTPAT_EN).
REQ-012 Port: iqsel  out  1  registered; 1 = data carries I, 0 = data carries Q.
REQ-013 Port: data  out  DW  registered interleaved sample component.
REQ-014 Port: fifo_level  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-015 Port: underflow_cnt  out  16  count of I-phases started with empty FIFO, saturating.

Function
REQ-016 The block SHALL drive the LMS ADC-side format: I word with iqsel=1 for one cycle, then Q word with iqsel=0 for one cycle.
REQ-017 FSM states SHALL be IDLE, PH_I, PH_Q; IDLE->PH_I when enable=1; PH_I->PH_Q always; PH_Q->PH_I if enable=1, else IDLE.
REQ-018 In IDLE, iqsel SHALL be 0 and data SHALL be 0.
REQ-019 On each transition into PH_I, the FIFO head SHALL be popped; data<=I, and the popped Q is held for PH_Q.
REQ-020 FIFO SHALL be show-ahead; minimum latency: sample written at edge N into empty FIFO appears as iqsel=1 at edge N+1 only if FSM enters PH_I at N+1 (no write-to-read bypass at same edge).
REQ-021 If FIFO is empty on entry to PH_I, data SHALL be 0 for both PH_I and PH_Q, and underflow_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-022 in_ready SHALL equal (fifo_level < 2^DEPTH_LOG2); no write when full.
REQ-023 Simultaneous push and pop SHALL leave fifo_level unchanged; pointers wrap modulo 2^DEPTH_LOG2.
REQ-024 Deassertion of enable during PH_I SHALL complete PH_Q before IDLE (no truncated sample).
REQ-025 FIFO contents SHALL be retained across IDLE; input acceptance SHALL continue while enable=0.

Reset
REQ-026 rst SHALL force state IDLE, iqsel=0, data=0, fifo_level=0, underflow_cnt=0, pointers 0, at the next clk edge, regardless of current phase.
REQ-027 in_ready SHALL be 1 on the first cycle after reset release.

Configuration
REQ-028 Macro LMS_RX_TESTPAT_EN SHALL compile the test-pattern source in or out.
REQ-029 With LMS_RX_TESTPAT_EN defined and testpat=1, PH_I/PH_Q SHALL output I=counter, Q=~counter (DW bits), counter incrementing once per sample, wrapping at 2^DW, reset to 0; FIFO not popped; underflow_cnt not incremented.
REQ-030 Without LMS_RX_TESTPAT_EN, testpat SHALL be ignored and no pattern logic SHALL exist.

Verification
REQ-031 Push (I=12'h123,Q=12'hABC) then enable=1 -> iqsel 1,0 with data 123, ABC on consecutive cycles.
REQ-032 Push 9 samples with DEPTH_LOG2=3, enable=0 -> in_ready=0 after 8th, fifo_level=8, 9th held until a pop.
REQ-033 enable=1 with empty FIFO for 3 samples -> data=0 throughout, underflow_cnt=3; preload 16'hFFFE-style force -> saturates at FFFF.
REQ-034 enable dropped during PH_I -> PH_Q still output, then iqsel=0, data=0, FIFO level reduced by exactly 1.
REQ-035 rst asserted in PH_Q with 5 queued -> next cycle iqsel=0, data=0, fifo_level=0, underflow_cnt=0, in_ready=1.
REQ-036 With LMS_RX_TESTPAT_EN, testpat=1, enable=1 -> I sequence 000,001,002; Q sequence FFF,FFE,FFD; FIFO level unchanged.
